// File: rtl/svm_pkg.sv
// Shared definitions for the SVM feature path.
// Used by the feature packer and the classifier.
package svm_pkg;

    localparam int FEATURE_DIM    = 8192;
    localparam int BYTES_PER_WORD = 16;
    localparam int WORD_W         = 128;

    typedef enum logic [2:0] {
        FILL,
        WRITE,
        PAD,
        DRAIN,
        DONE
    } pack_state_e;

endpackage

// File: rtl/byte_lane_packer.sv
// 16x8 lane register for the feature packer.
// Lanes at or above the fill index read as zero.
module byte_lane_packer
    import svm_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [3:0]        idx_i,
    input  logic [7:0]        data_i,
    input  logic [3:0]        lim_i,
    output logic [WORD_W-1:0] data_o
);

    logic [BYTES_PER_WORD-1:0][7:0] lanes_q;

    // Lane storage: write one lane per accept, wipe on reset/clear.
    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            lanes_q <= '0;
        end else if (we_i) begin
            lanes_q[idx_i] <= data_i;
        end
    end

    // Stale lanes from the previous word are hidden; lim 0 means all 16 filled.
    always_comb begin
        data_o = '0;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (lim_i == 4'd0 || 4'(k) < lim_i) begin
                data_o[8*k +: 8] = lanes_q[k];
            end
        end
    end

endmodule

// File: rtl/svm_feature_packer.sv
// Packs 8-bit features into 128-bit FIFO words.
// Pads short objects, drains and flags long ones.
module svm_feature_packer
    import svm_pkg::*;
#(
    parameter int FeatureDim = FEATURE_DIM
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        InData,
    input  logic              InValid,
    input  logic              InLast,
    output logic              InReady,
    output logic [WORD_W-1:0] WrData,
    input  logic              WrFull,
    output logic              WrFIFO,
    output logic              ObjectDone,
    output logic              Overflow
);

    localparam int WORDS = FeatureDim / BYTES_PER_WORD;
    localparam int WCW   = $clog2(WORDS) + 1;
    localparam logic [WCW-1:0] WORDS_C = WCW'(WORDS);

    pack_state_e    state_q, state_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [3:0]     byte_idx_q, byte_idx_d;
    logic           ovf_q, ovf_d;
    logic           last_q, last_d;

    logic              wr;
    logic              lane_we;
    logic              lane_clr;
    logic [WCW-1:0]    cnt_inc;
    logic [WORD_W-1:0] lane_word;

    byte_lane_packer u_lanes (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (lane_clr),
        .we_i   (lane_we),
        .idx_i  (byte_idx_q),
        .data_i (InData),
        .lim_i  (byte_idx_q),
        .data_o (lane_word)
    );

    // State, counters and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FILL;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            ovf_q      <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            ovf_q      <= ovf_d;
            last_q     <= last_d;
        end
    end

    // Next state and outputs; handshake outputs depend only on state and WrFull.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        ovf_d      = ovf_q;
        last_d     = last_q;
        InReady    = 1'b0;
        ObjectDone = 1'b0;
        Overflow   = 1'b0;
        WrData     = lane_word;
        wr         = 1'b0;
        lane_we    = 1'b0;
        lane_clr   = 1'b0;
        cnt_inc    = word_cnt_q + 1'b1;

        unique case (state_q)
            FILL: begin
                InReady = 1'b1;
                if (InValid) begin
                    lane_we    = 1'b1;
                    byte_idx_d = byte_idx_q + 4'd1;
                    if (InLast) begin
                        last_d = 1'b1;
                    end
                    if (byte_idx_q == 4'd15 || InLast) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                wr = !WrFull;
                if (wr) begin
                    word_cnt_d = cnt_inc;
                    byte_idx_d = '0;
                    if (cnt_inc == WORDS_C) begin
                        state_d = last_q ? DONE : DRAIN;
                    end else begin
                        state_d = last_q ? PAD : FILL;
                    end
                end
            end
            PAD: begin
                WrData = '0;
                wr     = !WrFull;
                if (wr) begin
                    word_cnt_d = cnt_inc;
                    if (cnt_inc == WORDS_C) begin
                        state_d = DONE;
                    end
                end
            end
            DRAIN: begin
                InReady = 1'b1;
                if (InValid) begin
                    ovf_d = 1'b1;
                    if (InLast) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                ObjectDone = 1'b1;
                Overflow   = ovf_q;
                word_cnt_d = '0;
                byte_idx_d = '0;
                ovf_d      = 1'b0;
                last_d     = 1'b0;
                lane_clr   = 1'b1;
                state_d    = FILL;
            end
            default: begin
                state_d = FILL;
            end
        endcase

        WrFIFO = wr && !reset;
        if (reset) begin
            InReady    = 1'b0;
            ObjectDone = 1'b0;
            Overflow   = 1'b0;
        end
    end

endmodule

// File: tb/tb_svm_feature_packer.sv
// Scoreboard bench for svm_feature_packer.
// Small instance (64 features) plus a default-size instance.
module tb_svm_feature_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         reset, in_valid, in_last, wr_full;
    logic [7:0]   in_data;
    logic         in_ready, wr_fifo, obj_done, ovf;
    logic [127:0] wr_data;

    logic         b_reset, b_valid, b_last, b_full;
    logic [7:0]   b_data;
    logic         b_ready, b_wr_fifo, b_done, b_ovf;
    logic [127:0] b_wr_data;

    svm_feature_packer #(.FeatureDim(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .InData     (in_data),
        .InValid    (in_valid),
        .InLast     (in_last),
        .InReady    (in_ready),
        .WrData     (wr_data),
        .WrFull     (wr_full),
        .WrFIFO     (wr_fifo),
        .ObjectDone (obj_done),
        .Overflow   (ovf)
    );

    svm_feature_packer #(.FeatureDim(8192)) dut_big (
        .clk        (clk),
        .reset      (b_reset),
        .InData     (b_data),
        .InValid    (b_valid),
        .InLast     (b_last),
        .InReady    (b_ready),
        .WrData     (b_wr_data),
        .WrFull     (b_full),
        .WrFIFO     (b_wr_fifo),
        .ObjectDone (b_done),
        .Overflow   (b_ovf)
    );

    int vecs = 0;
    int errs = 0;

    logic [127:0] exp_q[$];
    bit           done_q[$];
    int           done_cnt = 0;
    int           done_cyc = 0;
    int           first_acc = 0;
    bit           acc_seen = 0;

    logic [127:0] bexp_q[$];
    int           bdone_cnt = 0;
    int           b_wr_cnt = 0;

    localparam logic [127:0] W0  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] W1  = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
    localparam logic [127:0] W2  = 128'h2F2E2D2C_2B2A2928_27262524_23222120;
    localparam logic [127:0] W3  = 128'h3F3E3D3C_3B3A3938_37363534_33323130;
    localparam logic [127:0] S0  = 128'h100F0E0D_0C0B0A09_08070605_04030201;
    localparam logic [127:0] S1  = 128'h00000000_00000000_00000000_14131211;
    localparam logic [127:0] L1  = 128'h201F1E1D_1C1B1A19_18171615_14131211;
    localparam logic [127:0] L2  = 128'h302F2E2D_2C2B2A29_28272625_24232221;
    localparam logic [127:0] L3  = 128'h403F3E3D_3C3B3A39_38373635_34333231;

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        vecs++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic chk1(input string nm, input logic a, input logic e);
        vecs++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %b want %b", nm, a, e);
        end
    endtask

    task automatic chki(input string nm, input int a, input int e);
        vecs++;
        if (a != e) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", nm, a, e);
        end
    endtask

    // Monitor for the small instance.
    always @(negedge clk) begin
        if (wr_fifo === 1'b1) begin
            if (exp_q.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL unexpected_write: got %h want none", wr_data);
            end else begin
                chk("word", wr_data, exp_q.pop_front());
            end
        end
        if (obj_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (done_q.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL unexpected_done: got 1 want 0");
            end else begin
                chk1("overflow", ovf, done_q.pop_front());
            end
            chki("words_left_at_done", exp_q.size(), 0);
        end else if (ovf !== 1'b0 && reset === 1'b0) begin
            vecs++;
            errs++;
            $display("FAIL overflow_without_done: got %b want 0", ovf);
        end
    end

    // Monitor for the default-size instance.
    always @(negedge clk) begin
        if (b_wr_fifo === 1'b1) begin
            b_wr_cnt++;
            if (bexp_q.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL big_unexpected_write: got %h want none", b_wr_data);
            end else begin
                chk("big_word", b_wr_data, bexp_q.pop_front());
            end
        end
        if (b_done === 1'b1) begin
            bdone_cnt++;
            chk1("big_overflow", b_ovf, 1'b0);
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        bit r;
        int n;
        n = 0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = l;
        do begin
            @(negedge clk);
            r = (in_ready === 1'b1);
            if (r && !acc_seen) begin
                first_acc = cyc;
                acc_seen  = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 100);
        if (!r) begin
            vecs++;
            errs++;
            $display("FAIL accept_timeout: got no InReady want accept of %h", d);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic b_send(input logic [7:0] d, input logic l);
        bit r;
        int n;
        n = 0;
        b_data  = d;
        b_valid = 1'b1;
        b_last  = l;
        do begin
            @(negedge clk);
            r = (b_ready === 1'b1);
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 100);
        if (!r) begin
            vecs++;
            errs++;
            $display("FAIL big_accept_timeout: got no InReady want accept of %h", d);
        end
        b_valid = 1'b0;
        b_last  = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (done_cnt < target) begin
            vecs++;
            errs++;
            $display("FAIL done_timeout: got %0d dones want %0d", done_cnt, target);
        end
    endtask

    task automatic push_exact();
        exp_q.push_back(W0);
        exp_q.push_back(W1);
        exp_q.push_back(W2);
        exp_q.push_back(W3);
        done_q.push_back(1'b0);
    endtask

    initial begin
        logic [127:0] acc_w;
        logic [7:0]   d;
        int           n;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        wr_full  = 1'b0;
        b_reset  = 1'b1;
        b_valid  = 1'b0;
        b_last   = 1'b0;
        b_data   = '0;
        b_full   = 1'b0;
        acc_w    = '0;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_wr_fifo", wr_fifo, 1'b0);
        chk("rst_wr_data", wr_data, 128'd0);
        chk1("rst_obj_done", obj_done, 1'b0);
        chk1("rst_overflow", ovf, 1'b0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        b_reset = 1'b0;
        @(negedge clk);
        chk1("ready_after_reset", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Exact-length object, full rate.
        push_exact();
        acc_seen = 1'b0;
        for (int i = 0; i < 64; i++) send(8'(i), i == 63);
        wait_done(1);
        chki("exact_latency", done_cyc - first_acc + 1, 69);

        // Short object: 20 bytes then zero padding.
        exp_q.push_back(S0);
        exp_q.push_back(S1);
        exp_q.push_back(128'd0);
        exp_q.push_back(128'd0);
        done_q.push_back(1'b0);
        for (int i = 1; i <= 20; i++) send(8'(i), i == 20);
        wait_done(2);

        // Long object: 70 bytes, last 6 drained.
        exp_q.push_back(S0);
        exp_q.push_back(L1);
        exp_q.push_back(L2);
        exp_q.push_back(L3);
        done_q.push_back(1'b1);
        for (int i = 1; i <= 70; i++) send(8'(i), i == 70);
        wait_done(3);

        // Backpressure while word2 is held.
        push_exact();
        for (int i = 0; i < 47; i++) send(8'(i), 1'b0);
        wr_full = 1'b1;
        send(8'h2F, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk1("stall_no_write", wr_fifo, 1'b0);
            chk1("stall_not_ready", in_ready, 1'b0);
            chk("stall_data_held", wr_data, W2);
            @(posedge clk);
            #1;
        end
        wr_full = 1'b0;
        @(negedge clk);
        chk1("write_on_release", wr_fifo, 1'b1);
        @(posedge clk);
        #1;
        for (int i = 48; i < 64; i++) send(8'(i), i == 63);
        wait_done(4);

        // Reset after 30 bytes: word0 already out, partial word1 dropped.
        exp_q.push_back(W0);
        for (int i = 0; i < 30; i++) send(8'(i), 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk1("midrst_in_ready", in_ready, 1'b0);
            chk1("midrst_wr_fifo", wr_fifo, 1'b0);
            chk1("midrst_obj_done", obj_done, 1'b0);
            chk1("midrst_overflow", ovf, 1'b0);
            if (i == 1) chk("midrst_wr_data", wr_data, 128'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        chki("midrst_words_pending", exp_q.size(), 0);
        push_exact();
        for (int i = 0; i < 64; i++) send(8'(i), i == 63);
        wait_done(5);

        // Default size, random bytes with random idle gaps.
        for (int i = 0; i < 8192; i++) begin
            d = 8'($urandom_range(0, 255));
            acc_w[8*(i%16) +: 8] = d;
            if (i % 16 == 15) bexp_q.push_back(acc_w);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            b_send(d, i == 8191);
        end
        n = 0;
        while (bdone_cnt < 1 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        repeat (5) @(posedge clk);
        #1;
        chki("big_done_count", bdone_cnt, 1);
        chki("big_write_count", b_wr_cnt, 512);
        chki("big_words_left", bexp_q.size(), 0);
        chki("small_done_count", done_cnt, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
